// File: rtl/ram_responder.sv
// ram_responder
//   Responder end of a valid/ready RAM request protocol. Each accepted request
//   is performed on an internal single-port register-array RAM and produces
//   exactly one response, in acceptance order, READ_LATENCY cycles later
//   (when the response FIFO is empty). Responses are buffered so the
//   initiator may back-pressure without loss.
//
//   Handshake semantics (both channels): a transfer happens on a rising clk
//   edge where valid and ready are both high. The request channel accepts on
//   req_valid & req_ready; the response channel pops on resp_valid &
//   resp_ready. While resp_valid is high and resp_ready is low, resp_valid,
//   resp_write, resp_rdata (and resp_err) hold stable.
//
// Parameters:
//   WIDTH         data word width
//   ADDR_WIDTH    request address width
//   DEPTH         implemented words (1..2**ADDR_WIDTH)
//   READ_LATENCY  accept-to-response latency, 1..3
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req_valid/req_ready/req_write/req_addr/req_wdata   request channel
//   resp_valid/resp_ready/resp_write/resp_rdata        response channel
//   resp_err      (only with RAM_RESP_ERR_EN) address was >= DEPTH
//   busy          any request in flight or any response buffered
//
// Optional feature macro: RAM_RESP_ERR_EN adds resp_err.

module ram_responder #(
    parameter int WIDTH        = 32,
    parameter int ADDR_WIDTH   = 4,
    parameter int DEPTH        = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0]      req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_write,
    output logic [WIDTH-1:0]      resp_rdata,
`ifdef RAM_RESP_ERR_EN
    output logic                  resp_err,
`endif
    output logic                  busy
);

    // Capacity covers the latency pipeline plus enough FIFO slack to
    // sustain one request per cycle while responses are being popped.
    localparam int C  = READ_LATENCY + 2;
    localparam int PW = $clog2(C);
    localparam int CW = $clog2(C + 1);

    localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [PW-1:0]       PTR_LAST = PW'(C - 1);
    localparam logic [CW-1:0]       CAP      = CW'(C);

    logic [WIDTH-1:0] ram [0:DEPTH-1];

    // Stage 0 is the RAM output register; the remaining stages only delay.
    logic [WIDTH-1:0]        pipe_data [0:READ_LATENCY-1];
    logic [READ_LATENCY-1:0] pipe_valid;
    logic [READ_LATENCY-1:0] pipe_write;

    logic [WIDTH-1:0] fifo_data [0:C-1];
    logic [C-1:0]     fifo_write;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    fifo_count;
    logic [CW-1:0]    occ;

`ifdef RAM_RESP_ERR_EN
    logic [READ_LATENCY-1:0] pipe_err;
    logic [C-1:0]            fifo_err;
`endif

    logic             accept;
    logic             pop;
    logic             push;
    logic             in_range;
    logic [WIDTH-1:0] rd_word;

    assign accept   = req_valid & req_ready;
    assign pop      = resp_valid & resp_ready;
    assign push     = pipe_valid[READ_LATENCY-1];
    assign in_range = ({1'b0, req_addr} < DEPTH_L);
    assign rd_word  = in_range ? ram[req_addr] : '0;

    // RAM array: no reset, contents survive rst. Out-of-range writes drop.
    always_ff @(posedge clk) begin
        if (accept && req_write && in_range) begin
            ram[req_addr] <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            occ        <= '0;
        end else begin
            pipe_valid[0] <= accept;
            if (accept) begin
                pipe_write[0] <= req_write;
                pipe_data[0]  <= req_write ? req_wdata : rd_word;
`ifdef RAM_RESP_ERR_EN
                pipe_err[0]   <= ~in_range;
`endif
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_write[i] <= pipe_write[i-1];
                pipe_data[i]  <= pipe_data[i-1];
`ifdef RAM_RESP_ERR_EN
                pipe_err[i]   <= pipe_err[i-1];
`endif
            end

            // The occupancy limit guarantees a free FIFO slot for every push.
            if (push) begin
                fifo_data[wr_ptr]  <= pipe_data[READ_LATENCY-1];
                fifo_write[wr_ptr] <= pipe_write[READ_LATENCY-1];
`ifdef RAM_RESP_ERR_EN
                fifo_err[wr_ptr]   <= pipe_err[READ_LATENCY-1];
`endif
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            case ({accept, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Outputs are gated by resp_valid so an empty FIFO shows zeros.
    assign resp_valid = (fifo_count != '0);
    assign resp_write = resp_valid & fifo_write[rd_ptr];
    assign resp_rdata = resp_valid ? fifo_data[rd_ptr] : '0;
`ifdef RAM_RESP_ERR_EN
    assign resp_err   = resp_valid & fifo_err[rd_ptr];
`endif
    assign req_ready  = (occ < CAP);
    assign busy       = (occ != '0);

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder
//   Directed self-checking bench for ram_responder (DEPTH=12 so that the
//   out-of-range behaviour is reachable; READ_LATENCY=1). Each scenario task
//   drives stimulus and compares against hand-computed values or the bench's
//   own word model. Ends with a single summary line.

module tb_ram_responder;

    localparam int WIDTH = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 12;
    localparam int RL    = 1;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [AW-1:0]    req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_write;
    logic [WIDTH-1:0] resp_rdata;
    logic             busy;
`ifdef RAM_RESP_ERR_EN
    logic             resp_err;
`endif

    int checks;
    int errors;

    logic [WIDTH-1:0] model [0:15];
    logic [WIDTH:0]   exp_q [$];

    ram_responder #(
        .WIDTH       (WIDTH),
        .ADDR_WIDTH  (AW),
        .DEPTH       (DEPTH),
        .READ_LATENCY(RL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_write(resp_write),
        .resp_rdata(resp_rdata),
`ifdef RAM_RESP_ERR_EN
        .resp_err  (resp_err),
`endif
        .busy      (busy)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver: issue one request (resp_ready=1) and collect its response.
    // Caller guarantees nothing else is outstanding.
    task automatic single(input logic w, input logic [AW-1:0] a,
                          input logic [WIDTH-1:0] d,
                          output logic rw, output logic [WIDTH-1:0] rd,
                          output logic re, output logic ok);
        ok = 1'b1;
        rw = 1'b0;
        rd = '0;
        re = 1'b0;
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        for (int n = 0; n < 10 && !req_ready; n++) tick();
        if (!req_ready) ok = 1'b0;
        tick();
        req_valid = 1'b0;
        req_write = 1'b0;
        for (int n = 0; n < 10 && !resp_valid; n++) tick();
        if (!resp_valid) ok = 1'b0;
        rw = resp_write;
        rd = resp_rdata;
`ifdef RAM_RESP_ERR_EN
        re = resp_err;
`endif
        tick();
        if (w && int'(a) < DEPTH) model[a] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", resp_rdata); end
        checks++; if (resp_write !== 1'b0) begin errors++; $display("FAIL reset_resp_write got %b exp 0", resp_write); end
    endtask

    task automatic test_write_read();
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_addr   = 4'd3;
        req_wdata  = 32'hDEADBEEF;
        tick();                                  // edge k: write accepted
        model[3] = 32'hDEADBEEF;
        req_write = 1'b0;                        // read addr 3 at edge k+1
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL wr_early_valid got %b exp 0", resp_valid); end
        tick();
        req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL wr_resp_valid got %b exp 1", resp_valid); end
        checks++; if (resp_write !== 1'b1) begin errors++; $display("FAIL wr_resp_write got %b exp 1", resp_write); end
        checks++; if (resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_resp_data got %h exp deadbeef", resp_rdata); end
        tick();
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL rd_resp_valid got %b exp 1", resp_valid); end
        checks++; if (resp_write !== 1'b0) begin errors++; $display("FAIL rd_resp_write got %b exp 0", resp_write); end
        checks++; if (resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_after_wr_data got %h exp deadbeef", resp_rdata); end
        tick();
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wr_rd_idle got valid=%b busy=%b exp 0 0", resp_valid, busy); end
    endtask

    task automatic test_backpressure();
        logic rw, re, ok;
        logic [WIDTH-1:0] rd;
        int accepted;
        for (int i = 0; i < 8; i++) begin
            single(1'b1, 4'(i), 32'h1000_0000 + i, rw, rd, re, ok);
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_prefill_timeout addr %0d got %b exp 1", i, ok); end
        end
        resp_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = 4'(i);
            if (req_ready) accepted++;
            tick();
        end
        req_valid = 1'b0;
        checks++; if (accepted != 3) begin errors++; $display("FAIL bp_accept_count got %0d exp 3", accepted); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready got %b exp 0", req_ready); end
        for (int h = 0; h < 3; h++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_write !== 1'b0 || resp_rdata !== 32'h1000_0000) begin
                errors++;
                $display("FAIL bp_head_hold cycle %0d got v=%b w=%b d=%h exp 1 0 10000000", h, resp_valid, resp_write, resp_rdata);
            end
            tick();
        end
        resp_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h1000_0000 + j) begin
                errors++;
                $display("FAIL bp_drain %0d got v=%b d=%h exp 1 %h", j, resp_valid, resp_rdata, 32'h1000_0000 + j);
            end
            tick();
        end
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_drained got v=%b rdy=%b exp 0 1", resp_valid, req_ready); end
    endtask

    task automatic test_streaming();
        int idx, cyc, stalls, got;
        logic w;
        logic [AW-1:0] a;
        logic [WIDTH-1:0] d;
        logic [WIDTH:0] e;
        idx = 0; cyc = 0; stalls = 0; got = 0;
        resp_ready = 1'b1;
        while ((idx < 32 || exp_q.size() != 0) && cyc < 200) begin
            if (resp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra_resp got w=%b d=%h exp none", resp_write, resp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({resp_write, resp_rdata} !== e) begin
                        errors++;
                        $display("FAIL stream_resp %0d got w=%b d=%h exp w=%b d=%h", got, resp_write, resp_rdata, e[WIDTH], e[WIDTH-1:0]);
                    end
                end
                got++;
            end
            if (idx < 32) begin
                w = (idx < 16);
                a = 4'(idx % 16);
                d = 32'hC0DE_0000 | (idx * 32'h111);
                req_valid = 1'b1;
                req_write = w;
                req_addr  = a;
                req_wdata = d;
                if (req_ready) begin
                    if (w) begin
                        exp_q.push_back({1'b1, d});
                        if (int'(a) < DEPTH) model[a] = d;
                    end else begin
                        exp_q.push_back({1'b0, (int'(a) < DEPTH) ? model[a] : 32'h0});
                    end
                    idx++;
                end else begin
                    stalls++;
                end
            end else begin
                req_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        req_valid = 1'b0;
        req_write = 1'b0;
        checks++; if (stalls != 0) begin errors++; $display("FAIL stream_stalls got %0d exp 0", stalls); end
        checks++; if (got != 32) begin errors++; $display("FAIL stream_resp_count got %0d exp 32", got); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_pending got %0d exp 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic rw, re, ok;
        logic [WIDTH-1:0] rd;
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 4'd5;
        tick();
        req_addr = 4'd6;
        tick();
        req_valid = 1'b0;
        checks++; if (busy !== 1'b1 || resp_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre got busy=%b v=%b exp 1 1", busy, resp_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", resp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", req_ready); end
        resp_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ghost_resp cycle %0d got %b exp 0", n, resp_valid); end
        end
        single(1'b0, 4'd5, 32'h0, rw, rd, re, ok);
        checks++; if (ok !== 1'b1 || rw !== 1'b0 || rd !== model[5]) begin errors++; $display("FAIL rstmid_ram_kept got ok=%b w=%b d=%h exp 1 0 %h", ok, rw, rd, model[5]); end
    endtask

    task automatic test_out_of_range();
        logic rw, re, ok;
        logic [WIDTH-1:0] rd;
        single(1'b0, 4'd14, 32'h0, rw, rd, re, ok);
        checks++; if (ok !== 1'b1 || rw !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL oor_read14 got ok=%b w=%b d=%h exp 1 0 0", ok, rw, rd); end
`ifdef RAM_RESP_ERR_EN
        checks++; if (re !== 1'b1) begin errors++; $display("FAIL oor_read14_err got %b exp 1", re); end
`endif
        single(1'b1, 4'd13, 32'h1234_5678, rw, rd, re, ok);
        checks++; if (ok !== 1'b1 || rw !== 1'b1) begin errors++; $display("FAIL oor_write13 got ok=%b w=%b exp 1 1", ok, rw); end
`ifdef RAM_RESP_ERR_EN
        checks++; if (re !== 1'b1) begin errors++; $display("FAIL oor_write13_err got %b exp 1", re); end
`endif
        single(1'b0, 4'd13, 32'h0, rw, rd, re, ok);
        checks++; if (ok !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL oor_read13 got ok=%b d=%h exp 1 0", ok, rd); end
        single(1'b0, 4'd1, 32'h0, rw, rd, re, ok);
        checks++; if (ok !== 1'b1 || rd !== model[1]) begin errors++; $display("FAIL oor_no_alias got ok=%b d=%h exp 1 %h", ok, rd, model[1]); end
`ifdef RAM_RESP_ERR_EN
        checks++; if (re !== 1'b0) begin errors++; $display("FAIL inrange_err got %b exp 0", re); end
`endif
        single(1'b0, 4'd11, 32'h0, rw, rd, re, ok);
        checks++; if (ok !== 1'b1 || rd !== model[11]) begin errors++; $display("FAIL last_word_read got ok=%b d=%h exp 1 %h", ok, rd, model[11]); end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = '0;

        test_reset();
        test_write_read();
        test_backpressure();
        test_streaming();
        test_reset_mid();
        test_out_of_range();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Responder end of the start/ready/done style RAM request protocol.
- Accepts read/write requests from an initiator such as a read_write_ram-class controller through a valid/ready handshake and performs them on an internal single-port register-array RAM.
- Returns exactly one in-order response per accepted request after a fixed latency.
- Buffers responses so the initiator can apply back-pressure without losing data.

Parameters:
- WIDTH, 32, data word width in bits.
- ADDR_WIDTH, 4, request address width.
- DEPTH, 16, number of words implemented; 1 <= DEPTH <= 2**ADDR_WIDTH.
- READ_LATENCY, 1, accept-to-response latency in cycles; legal values 1..3.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; registered state only, no combinational path from any input.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  WIDTH  write data.
- resp_valid  out  1  response present at FIFO head.
- resp_ready  in  1  initiator takes the response.
- resp_write  out  1  echo of req_write for this response.
- resp_rdata  out  WIDTH  read data; for write responses, the written data.
- busy  out  1  any request in flight or any response buffered.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.

Handshake and ordering:
- Request accept = req_valid & req_ready at a clk edge. Response pop = resp_valid & resp_ready.
- Responses return in acceptance order.

Timing and capacity:
- Capacity C = READ_LATENCY + 2 outstanding requests, counting both the in-flight pipeline and the response FIFO.
- occupancy = in_flight + fifo_count; req_ready = (occupancy < C).
- Pop and accept on the same edge: occupancy is unchanged.
- With resp_ready held at 1, throughput is 1 request per cycle with no stalls.
- Request accepted at edge k: if the FIFO is empty, resp_valid is high, with data, immediately after edge k + READ_LATENCY.

Memory semantics:
- Write: the array is updated at the accept edge.
- Read: data is sampled from the array at the accept edge.
- A read accepted on the edge after a write to the same address returns the new data.
- Only one request can be accepted per cycle, so there are no port collisions.
- Out-of-range address (addr >= DEPTH), base build: write is discarded; read returns 0; a response is still generated.

Response holding:
- While resp_valid=1 and resp_ready=0, resp_valid, resp_write and resp_rdata hold stable.
- When the FIFO is full and nothing is popping, req_ready=0.

Reset:
- Output values: req_ready=1 (occupancy 0); resp_valid=0; resp_write=0; resp_rdata=0; busy=0.
- Reset mid-operation discards the in-flight pipeline and all FIFO contents. No response is emitted for discarded requests.
- RAM array contents are not cleared by reset.

busy = (occupancy != 0).

State machine: none beyond the following.
- Latency shift pipeline of READ_LATENCY-1 stages.
- Circular FIFO with read/write pointers that wrap modulo C.
- Occupancy counter sized ceil(log2(C+1)) bits.

Optional Feature:
- Macro: RAM_RESP_ERR_EN.
- Defined:
  - Adds output port resp_err (1 bit, reset 0), carried with each response.
  - resp_err=1 for any request with addr >= DEPTH.
  - Out-of-range writes are discarded and out-of-range reads return 0, as in the base build.
- Undefined:
  - No resp_err port.
  - Out-of-range access is silent, as described in Behaviour.

Test Plan:
- Reset, then idle with req_valid=0 -> req_ready=1, resp_valid=0, busy=0, resp_rdata=0.
- Write addr 3 data 0xDEADBEEF at edge k, read addr 3 at edge k+1, resp_ready=1, READ_LATENCY=1 -> write response (resp_write=1, rdata 0xDEADBEEF) after edge k+1; read response (resp_write=0, 0xDEADBEEF) after edge k+2.
- resp_ready=0; back-to-back reads of addr 0..7 with READ_LATENCY=1 -> exactly 3 accepted, req_ready=0 thereafter, head holds addr 0 data stable. Then resp_ready=1 -> remaining responses drain in order.
- Streaming 16 writes then 16 reads with resp_ready=1 -> req_ready never drops; reads return the written values in order.
- Assert rst with 2 requests outstanding -> next cycle resp_valid=0, busy=0, req_ready=1; a subsequent read of a previously written address returns the old data.
- DEPTH=12, read addr 14 with RAM_RESP_ERR_EN defined -> rdata 0, resp_err=1. Write addr 13 -> resp_err=1 and the array is unchanged.
